mem_req_port: RTL and testbench

MEM_REQ_PORT -- requirements
Module: mem_req_port

---
 rtl/mem_port_pkg.sv | 20 ++
 rtl/req_fifo.sv | 61 ++++++
 rtl/mem_req_port.sv | 128 ++++++++++++
 tb/tb_mem_req_port.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types for the memory request port: FSM states, default widths and
// the request entry that travels through the request FIFO.
package mem_port_pkg;

  localparam int unsigned MP_AW = 16;
  localparam int unsigned MP_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic             we;
    logic [MP_AW-1:0] addr;
    logic [MP_DW-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO for mem_req_port: DEPTH entries (power of two), count 0..DEPTH,
// head visible on rdata_o while not empty.
module req_fifo
  import mem_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  req_entry_t               wdata_i,
  input  logic                     pop_i,
  output req_entry_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  req_entry_t          mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW:0]         count_q;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; only pointers and count define
  // validity, so clearing the array would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_port.sv
// CPU-side memory request port: queues CPU loads/stores and issues them one at
// a time to the IO arbiter, returning load data to the CPU in order.
module mem_req_port
  import mem_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = MP_AW,
  parameter int unsigned DW    = MP_DW
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          cpu_req_valid,
  output logic          cpu_req_ready,
  input  logic          cpu_req_we,
  input  logic [AW-1:0] cpu_req_addr,
  input  logic [DW-1:0] cpu_req_wdata,
  output logic          cpu_rsp_valid,
  output logic [DW-1:0] cpu_rsp_rdata,
  input  logic          cpu_rsp_ready,
  output logic          io_write_req,
  output logic          io_read_req,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_data,
  input  logic          io_done,
  input  logic [DW-1:0] io_rdata
);

  state_e                state_q, state_d;
  logic                  io_write_req_q, io_write_req_d;
  logic                  io_read_req_q, io_read_req_d;
  logic [AW-1:0]         io_addr_q, io_addr_d;
  logic [DW-1:0]         io_data_q, io_data_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;

  req_entry_t            push_entry;
  req_entry_t            head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign cpu_req_ready = !fifo_full;
  assign fifo_push     = cpu_req_valid && cpu_req_ready;
  assign push_entry    = '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};

  req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk     (Clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every next-state signal takes its held value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    io_write_req_d = io_write_req_q;
    io_read_req_d  = io_read_req_q;
    io_addr_d      = io_addr_q;
    io_data_d      = io_data_q;
    rsp_rdata_d    = rsp_rdata_q;
    fifo_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          state_d        = ISSUE;
          io_write_req_d = head.we;
          io_read_req_d  = !head.we;
          io_addr_d      = head.addr;
          io_data_d      = head.wdata;
        end
      end
      ISSUE: begin
        // The head stays in the FIFO until the arbiter finishes with it.
        if (io_done) begin
          fifo_pop       = !fifo_empty;
          io_write_req_d = 1'b0;
          io_read_req_d  = 1'b0;
          if (io_read_req_q) begin
            rsp_rdata_d = io_rdata;
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        if (cpu_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      io_write_req_q <= 1'b0;
      io_read_req_q  <= 1'b0;
      io_addr_q      <= '0;
      io_data_q      <= '0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      io_write_req_q <= io_write_req_d;
      io_read_req_q  <= io_read_req_d;
      io_addr_q      <= io_addr_d;
      io_data_q      <= io_data_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign io_write_req  = io_write_req_q;
  assign io_read_req   = io_read_req_q;
  assign io_addr       = io_addr_q;
  assign io_data       = io_data_q;
  assign cpu_rsp_valid = (state_q == RESP);
  assign cpu_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_port.sv
// Directed self-checking bench for mem_req_port: loads, stores, back-pressure,
// stalled responses, reset mid-transaction and stray io_done.
module tb_mem_req_port;

  logic        Clk;
  logic        reset_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [15:0] cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [15:0] cpu_rsp_rdata;
  logic        cpu_rsp_ready;
  logic        io_write_req;
  logic        io_read_req;
  logic [15:0] io_addr;
  logic [15:0] io_data;
  logic        io_done;
  logic [15:0] io_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_req_port #(.DEPTH(4), .AW(16), .DW(16)) dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .cpu_rsp_ready (cpu_rsp_ready),
    .io_write_req  (io_write_req),
    .io_read_req   (io_read_req),
    .io_addr       (io_addr),
    .io_data       (io_data),
    .io_done       (io_done),
    .io_rdata      (io_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
  endtask

  // Waits (bounded) for the expected request bit, checks it, then completes it.
  task automatic finish_req(input string tag, input logic is_read, input logic [15:0] exp_addr,
                            input logic [15:0] exp_data, input logic [15:0] rdata);
    int n = 0;
    while (!(is_read ? io_read_req : io_write_req) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_issued"}, is_read ? io_read_req : io_write_req, 1);
    check({tag, "_other_bit"}, is_read ? io_write_req : io_read_req, 0);
    check({tag, "_addr"}, io_addr, exp_addr);
    if (!is_read) check({tag, "_data"}, io_data, exp_data);
    io_done  = 1'b1;
    io_rdata = rdata;
    tick();
    io_done  = 1'b0;
    io_rdata = 16'h0;
    check({tag, "_req_dropped"}, {io_write_req, io_read_req}, 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 16'h0;
    cpu_req_wdata = 16'h0;
    cpu_rsp_ready = 1'b0;
    io_done       = 1'b0;
    io_rdata      = 16'h0;

    // Reset state
    tick();
    tick();
    check("rst_write_req", io_write_req, 0);
    check("rst_read_req", io_read_req, 0);
    check("rst_rsp_valid", cpu_rsp_valid, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_data", io_data, 0);
    check("rst_rsp_rdata", cpu_rsp_rdata, 0);
    reset_n = 1'b1;
    tick();
    check("rst_ready_after_release", cpu_req_ready, 1);

    // Single load with minimum latency and a 3-cycle arbiter wait
    drive_req(1'b0, 16'h0010, 16'h0);
    tick();
    cpu_req_valid = 1'b0;
    check("ld_cycle1_idle", io_read_req, 0);
    tick();
    check("ld_cycle2_read_req", io_read_req, 1);
    check("ld_cycle2_addr", io_addr, 16'h0010);
    check("ld_cycle2_no_write", io_write_req, 0);
    tick();
    tick();
    check("ld_held", io_read_req, 1);
    check("ld_no_rsp_yet", cpu_rsp_valid, 0);
    io_done  = 1'b1;
    io_rdata = 16'hBEEF;
    tick();
    io_done  = 1'b0;
    io_rdata = 16'h0;
    check("ld_req_low_after_done", io_read_req, 0);
    check("ld_rsp_valid", cpu_rsp_valid, 1);
    check("ld_rsp_data", cpu_rsp_rdata, 16'hBEEF);
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
    check("ld_rsp_accepted", cpu_rsp_valid, 0);

    // Single store: no CPU response
    drive_req(1'b1, 16'h0020, 16'h1234);
    tick();
    cpu_req_valid = 1'b0;
    tick();
    check("st_rsp_none_issue", cpu_rsp_valid, 0);
    tick();
    tick();
    finish_req("st", 1'b0, 16'h0020, 16'h1234, 16'h0);
    check("st_no_rsp", cpu_rsp_valid, 0);
    tick();
    check("st_no_rsp_later", cpu_rsp_valid, 0);

    // Five back-to-back stores with io_done held low
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
      check($sformatf("bp_ready_%0d", i), cpu_req_ready, 1);
      tick();
    end
    drive_req(1'b1, 16'h0104, 16'hA004);
    check("bp_ready_full", cpu_req_ready, 0);
    tick();
    check("bp_ready_still_full", cpu_req_ready, 0);
    check("bp_head_held", io_addr, 16'h0100);
    finish_req("bp0", 1'b0, 16'h0100, 16'hA000, 16'h0);
    check("bp_ready_reopen", cpu_req_ready, 1);
    tick();
    cpu_req_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      finish_req($sformatf("bp%0d", i), 1'b0, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 16'h0);
    end
    tick();
    check("bp_drained", io_write_req, 0);

    // Load stalled by cpu_rsp_ready with a store queued behind it
    drive_req(1'b0, 16'h0030, 16'h0);
    tick();
    drive_req(1'b1, 16'h0040, 16'h5555);
    tick();
    cpu_req_valid = 1'b0;
    finish_req("stall_ld", 1'b1, 16'h0030, 16'h0, 16'hCAFE);
    io_rdata = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_valid_%0d", i), cpu_rsp_valid, 1);
      check($sformatf("stall_data_%0d", i), cpu_rsp_rdata, 16'hCAFE);
      check($sformatf("stall_next_held_%0d", i), io_write_req, 0);
      io_done = (i == 1);
      tick();
      io_done = 1'b0;
    end
    io_rdata = 16'h0;
    check("stall_valid_before_accept", cpu_rsp_valid, 1);
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
    check("stall_rsp_cleared", cpu_rsp_valid, 0);
    check("stall_idle_gap", io_write_req, 0);
    finish_req("stall_st", 1'b0, 16'h0040, 16'h5555, 16'h0);

    // Reset mid-ISSUE with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 16'h0050 + 16'(i), 16'h0);
      tick();
    end
    cpu_req_valid = 1'b0;
    check("mid_rst_issue", io_read_req, 1);
    check("mid_rst_issue_addr", io_addr, 16'h0050);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_read_req_zero", io_read_req, 0);
    check("mid_rst_addr_zero", io_addr, 0);
    check("mid_rst_ready", cpu_req_ready, 1);
    @(negedge Clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", cpu_req_ready, 1);
    tick();
    tick();
    check("post_rst_no_issue", {io_write_req, io_read_req}, 0);
    check("post_rst_no_rsp", cpu_rsp_valid, 0);

    // io_done while IDLE is ignored
    drive_req(1'b1, 16'h0060, 16'h6666);
    io_done = 1'b1;
    tick();
    cpu_req_valid = 1'b0;
    check("idle_done_no_issue", io_write_req, 0);
    tick();
    io_done = 1'b0;
    check("idle_done_entry_kept", io_write_req, 1);
    check("idle_done_addr", io_addr, 16'h0060);
    finish_req("idle_done", 1'b0, 16'h0060, 16'h6666, 16'h0);
    tick();
    tick();
    check("idle_done_empty", {io_write_req, io_read_req}, 0);
    check("idle_done_ready", cpu_req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
